// File: rtl/flash_read_arbiter.sv
// SPI flash read controller (mode 0, single-bit, command 0x03) shared round-robin
// between two requesters; each request returns one little-endian 32-bit word.
module flash_read_arbiter #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [23:0] m0_addr,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [23:0] m1_addr,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_io0_en,
  output logic        flash_io0_out,
  input  logic        flash_io0_in,
  output logic        flash_io1_en,
  output logic        flash_io1_out,
  input  logic        flash_io1_in
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       CMD_READ = 8'h03;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic [30:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [6:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              csn_q, csn_d;
  logic              sck_q, sck_d;
  logic              io0_en_q, io0_en_d;
  logic              io0_out_q, io0_out_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;
  logic              pick_m1;
  logic [31:0]       cmd_word;
  logic              unused_io0_in;

  // Bytes arrive in address order, so the first byte lands in the top of rx_q.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign unused_io0_in = flash_io0_in;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    csn_d        = csn_q;
    sck_d        = sck_q;
    io0_en_d     = io0_en_q;
    io0_out_d    = io0_out_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    pick_m1      = m1_req && (!m0_req || !last_grant_q);
    cmd_word     = {CMD_READ, pick_m1 ? m1_addr : m0_addr};
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d        = pick_m1;
          last_grant_d = pick_m1;
          tx_d         = cmd_word[30:0];
          csn_d        = 1'b0;
          io0_en_d     = 1'b1;
          io0_out_d    = cmd_word[31];
          sck_d        = 1'b0;
          bit_cnt_d    = '0;
          div_cnt_d    = '0;
          state_d      = LEAD;
        end
      end
      // One extra clk of CS-to-SCK setup so the completion edge lands one cycle later.
      LEAD: state_d = SHIFT;
      SHIFT: begin
        if (div_cnt_q != DIV_LAST) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
          div_cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            if (bit_cnt_q >= 7'd32) rx_d = {rx_q[30:0], flash_io1_in};
          end else begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q == 7'd63) begin
              csn_d     = 1'b1;
              io0_en_d  = 1'b0;
              io0_out_d = 1'b0;
              gap_cnt_d = '0;
              state_d   = GAP;
              if (gnt_q) begin
                m1_ack_d   = 1'b1;
                m1_rdata_d = byte_swap(rx_q);
              end else begin
                m0_ack_d   = 1'b1;
                m0_rdata_d = byte_swap(rx_q);
              end
            end else if (bit_cnt_q == 7'd31) begin
              io0_en_d  = 1'b0;
              io0_out_d = 1'b0;
            end else begin
              io0_out_d = tx_q[30];
              tx_d      = {tx_q[29:0], 1'b0};
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      csn_q        <= 1'b1;
      sck_q        <= 1'b0;
      io0_en_q     <= 1'b0;
      io0_out_q    <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      csn_q        <= csn_d;
      sck_q        <= sck_d;
      io0_en_q     <= io0_en_d;
      io0_out_q    <= io0_out_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign flash_clk     = sck_q;
  assign flash_csn     = csn_q;
  assign flash_io0_en  = io0_en_q;
  assign flash_io0_out = io0_out_q;
  assign flash_io1_en  = 1'b0;
  assign flash_io1_out = 1'b0;
  assign m0_ack        = m0_ack_q;
  assign m1_ack        = m1_ack_q;
  assign m0_rdata      = m0_rdata_q;
  assign m1_rdata      = m1_rdata_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: behavioural SPI flash, transaction monitor and
// per-scenario tasks comparing acks/data/latency against a byte-level memory model.
module tb_flash_read_arbiter;
  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 4;
  localparam int LAT        = 128 * CLK_DIV + 1;
  localparam int TX_BUDGET  = 400;

  logic        clk = 1'b0, reset = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [23:0] m0_addr = '0, m1_addr = '0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        flash_clk, flash_csn, flash_io0_en, flash_io0_out;
  logic        flash_io1_en, flash_io1_out;
  logic        flash_io0_in = 1'b0, flash_io1_in = 1'b0;

  flash_read_arbiter #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .flash_clk(flash_clk), .flash_csn(flash_csn),
    .flash_io0_en(flash_io0_en), .flash_io0_out(flash_io0_out), .flash_io0_in(flash_io0_in),
    .flash_io1_en(flash_io1_en), .flash_io1_out(flash_io1_out), .flash_io1_in(flash_io1_in)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash contents; 4 KiB image aliased across the 24-bit space.
  logic [7:0] mem [0:4095];
  logic [31:0] exp_last0 = '0, exp_last1 = '0;

  function automatic logic [7:0] mem_at(input logic [23:0] a);
    return mem[a[11:0]];
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = mem_at(a + 24'(j));
    return w;
  endfunction

  // Behavioural SPI flash: capture cmd/addr on rising SCK, drive data after falling SCK.
  int          nbits = 0;
  logic [31:0] fl_ca = '0;
  int          en_err = 0;
  always @(negedge flash_csn) begin
    nbits = 0; fl_ca = '0; en_err = 0;
  end
  always @(posedge flash_clk) begin
    if (!flash_csn) begin
      if (nbits < 32) begin
        fl_ca = {fl_ca[30:0], flash_io0_out};
        if (flash_io0_en !== 1'b1) en_err++;
      end else if (flash_io0_en !== 1'b0) en_err++;
      nbits++;
    end
  end
  always @(negedge flash_clk) begin
    int d;
    logic [7:0] b;
    if (!flash_csn && nbits >= 32 && nbits < 64) begin
      d = nbits - 32;
      b = mem_at(fl_ca[23:0] + 24'(d / 8));
      flash_io1_in = b[7 - (d % 8)];
    end
  end

  // Transaction monitor
  typedef struct {
    int          port;
    logic [31:0] data;
    logic [31:0] other;
    int          lat;
    logic        csn;
    logic [31:0] ca;
    int          enerr;
  } ev_t;
  ev_t  ev_q[$];
  int   gap_q[$];
  int   ack_cnt0 = 0, ack_cnt1 = 0, dbl_ack = 0;
  logic csn_prev = 1'b1;
  int   fall_cyc = 0, rise_cyc = 0;
  bit   have_rise = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (reset) have_rise = 1'b0;
    if (csn_prev && !flash_csn) begin
      fall_cyc = cyc;
      if (have_rise) gap_q.push_back(cyc - rise_cyc);
      have_rise = 1'b0;
    end
    if (m0_ack || m1_ack) begin
      if (m0_ack && m1_ack) dbl_ack++;
      e.port  = m1_ack ? 1 : 0;
      e.data  = m1_ack ? m1_rdata : m0_rdata;
      e.other = m1_ack ? m0_rdata : m1_rdata;
      e.lat   = cyc - fall_cyc;
      e.csn   = flash_csn;
      e.ca    = fl_ca;
      e.enerr = en_err;
      ev_q.push_back(e);
      if (m0_ack) ack_cnt0++;
      if (m1_ack) ack_cnt1++;
      rise_cyc  = cyc;
      have_rise = 1'b1;
    end
    csn_prev = flash_csn;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ev_q.delete(); gap_q.delete();
    ack_cnt0 = 0; ack_cnt1 = 0; exp_last0 = '0; exp_last1 = '0;
  endtask

  task automatic wait_evs(input int n, output bit ok);
    int c = 0;
    while (ev_q.size() < n && c < TX_BUDGET * 2) begin @(posedge clk); c++; end
    ok = (ev_q.size() >= n);
    #1;
  endtask

  task automatic wait_port(input int p, input int target, output bit ok);
    int c = 0;
    while (((p == 1) ? ack_cnt1 : ack_cnt0) < target && c < TX_BUDGET * 3) begin
      @(posedge clk); c++;
    end
    ok = (((p == 1) ? ack_cnt1 : ack_cnt0) >= target);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    repeat (2) @(posedge clk); #1;
    obs = {flash_csn, flash_clk, flash_io0_en, flash_io0_out,
           flash_io1_en, flash_io1_out, m0_ack, m1_ack};
    checks++;
    if (obs !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_pins got %b exp %b", obs, 8'b1000_0000);
    end
    checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", m0_rdata, m1_rdata);
    end
    reset = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++;
    if (flash_csn !== 1'b1 || flash_io1_en !== 1'b0) begin
      errors++; $display("FAIL idle_csn got %b exp 1", flash_csn);
    end
  endtask

  task automatic test_single();
    bit ok;
    ev_t e;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    m0_addr = 24'h000100; m0_req = 1'b1;
    wait_evs(1, ok);
    m0_req = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got 0 acks exp 1"); return; end
    e = ev_q[0];
    checks++;
    if (e.port !== 0 || e.data !== 32'h44332211) begin
      errors++; $display("FAIL single_data got port %0d %h exp port 0 44332211", e.port, e.data);
    end
    checks++;
    if (e.lat !== LAT || e.csn !== 1'b1) begin
      errors++; $display("FAIL single_latency got %0d csn %b exp %0d csn 1", e.lat, e.csn, LAT);
    end
    checks++;
    if (e.ca !== 32'h03000100 || e.enerr !== 0) begin
      errors++; $display("FAIL single_mosi got %h enerr %0d exp 03000100 enerr 0", e.ca, e.enerr);
    end
    checks++;
    if (e.other !== exp_last1) begin
      errors++; $display("FAIL single_m1_hold got %h exp %h", e.other, exp_last1);
    end
    exp_last0 = 32'h44332211;
    repeat (30) @(posedge clk); #1;
    checks++;
    if (ev_q.size() !== 1) begin
      errors++; $display("FAIL single_ack_count got %0d exp 1", ev_q.size());
    end
  endtask

  task automatic test_simultaneous();
    bit ok0, ok1;
    logic [23:0] a [2];
    do_reset();
    a[0] = 24'($urandom); a[1] = 24'($urandom);
    m0_addr = a[0]; m1_addr = a[1]; m0_req = 1'b1; m1_req = 1'b1;
    fork
      begin wait_port(0, 1, ok0); m0_req = 1'b0; end
      begin wait_port(1, 1, ok1); m1_req = 1'b0; end
    join
    repeat (50) @(posedge clk); #1;
    checks++;
    if (ev_q.size() !== 2 || !ok0 || !ok1) begin
      errors++; $display("FAIL simul_ack_count got %0d exp 2", ev_q.size()); return;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ev_q[i].port !== i || ev_q[i].data !== exp_word(a[i]) ||
          ev_q[i].ca !== {8'h03, a[i]} || ev_q[i].lat !== LAT) begin
        errors++;
        $display("FAIL simul_tx%0d got port %0d data %h ca %h lat %0d exp port %0d data %h ca %h lat %0d",
                 i, ev_q[i].port, ev_q[i].data, ev_q[i].ca, ev_q[i].lat,
                 i, exp_word(a[i]), {8'h03, a[i]}, LAT);
      end
    end
    checks++;
    if (gap_q.size() < 1 || gap_q[0] < GAP_CYCLES) begin
      errors++; $display("FAIL simul_gap got %0d exp >= %0d",
                         (gap_q.size() > 0) ? gap_q[0] : -1, GAP_CYCLES);
    end
    exp_last0 = exp_word(a[0]); exp_last1 = exp_word(a[1]);
  endtask

  task automatic test_round_robin();
    logic [23:0] l0 [4], l1 [4], a;
    logic [31:0] last [2];
    int k0 = 0, k1 = 0;
    bit ok = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin l0[i] = 24'($urandom); l1[i] = 24'($urandom); end
    m0_addr = l0[0]; m1_addr = l1[0]; m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 6 && ok; i++) begin
      wait_evs(i + 1, ok);
      if (ok) begin
        if (ev_q[i].port == 0) begin k0++; m0_addr = l0[k0]; end
        else begin k1++; m1_addr = l1[k1]; end
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (50) @(posedge clk); #1;
    checks++;
    if (ev_q.size() !== 6) begin
      errors++; $display("FAIL rr_ack_count got %0d exp 6", ev_q.size()); return;
    end
    last[0] = '0; last[1] = '0;
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? l0[i / 2] : l1[i / 2];
      checks++;
      if (ev_q[i].port !== (i % 2) || ev_q[i].data !== exp_word(a) || ev_q[i].ca !== {8'h03, a}) begin
        errors++;
        $display("FAIL rr_tx%0d got port %0d data %h ca %h exp port %0d data %h ca %h",
                 i, ev_q[i].port, ev_q[i].data, ev_q[i].ca, i % 2, exp_word(a), {8'h03, a});
      end
      checks++;
      if (ev_q[i].other !== last[1 - (i % 2)]) begin
        errors++; $display("FAIL rr_hold%0d got %h exp %h", i, ev_q[i].other, last[1 - (i % 2)]);
      end
      last[i % 2] = exp_word(a);
    end
    exp_last0 = last[0]; exp_last1 = last[1];
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n0 = ev_q.size();
    int c0 = ack_cnt0;
    logic [23:0] a [2];
    a[0] = 24'h000000; a[1] = 24'h000004;
    m1_addr = a[0]; m1_req = 1'b1;
    wait_evs(n0 + 1, ok);
    m1_addr = a[1];
    if (ok) wait_evs(n0 + 2, ok);
    m1_req = 1'b0;
    repeat (40) @(posedge clk); #1;
    checks++;
    if (ev_q.size() !== n0 + 2) begin
      errors++; $display("FAIL b2b_ack_count got %0d exp %0d", ev_q.size(), n0 + 2); return;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ev_q[n0 + i].port !== 1 || ev_q[n0 + i].data !== exp_word(a[i]) ||
          ev_q[n0 + i].ca !== {8'h03, a[i]} || ev_q[n0 + i].other !== exp_last0) begin
        errors++;
        $display("FAIL b2b_tx%0d got port %0d data %h m0_rdata %h exp port 1 data %h m0_rdata %h",
                 i, ev_q[n0 + i].port, ev_q[n0 + i].data, ev_q[n0 + i].other, exp_word(a[i]), exp_last0);
      end
    end
    checks++;
    if (ack_cnt0 !== c0) begin
      errors++; $display("FAIL b2b_m0_ack got %0d exp %0d", ack_cnt0, c0);
    end
    exp_last1 = exp_word(a[1]);
  endtask

  task automatic test_reset_midtx();
    bit ok;
    int c = 0, n;
    logic [23:0] a;
    logic [4:0] obs;
    m0_addr = 24'($urandom); m0_req = 1'b1;
    while ((flash_csn || nbits < 40) && c < TX_BUDGET) begin @(posedge clk); c++; end
    checks++;
    if (flash_csn || nbits < 40) begin
      errors++; $display("FAIL rst_reach_bit40 got %0d exp 40", nbits); return;
    end
    @(posedge clk); #2 reset = 1'b1;
    #1;
    obs = {flash_csn, flash_clk, flash_io0_en, m0_ack, m1_ack};
    checks++;
    if (obs !== 5'b10000) begin
      errors++; $display("FAIL rst_async_pins got %b exp 10000", obs);
    end
    n = ev_q.size();
    repeat (2) @(posedge clk); #1;
    reset = 1'b0; m0_req = 1'b0; exp_last0 = '0; exp_last1 = '0;
    repeat (300) @(posedge clk); #1;
    checks++;
    if (ev_q.size() !== n || m0_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_no_ack got %0d acks rdata %h exp %0d acks rdata 0", ev_q.size(), m0_rdata, n);
    end
    a = 24'($urandom); m1_addr = a; m1_req = 1'b1;
    wait_evs(n + 1, ok);
    m1_req = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_next_timeout got 0 acks exp 1"); return; end
    checks++;
    if (ev_q[n].port !== 1 || ev_q[n].data !== exp_word(a) || ev_q[n].lat !== LAT ||
        ev_q[n].ca !== {8'h03, a}) begin
      errors++;
      $display("FAIL rst_next_tx got port %0d data %h lat %0d ca %h exp port 1 data %h lat %0d ca %h",
               ev_q[n].port, ev_q[n].data, ev_q[n].lat, ev_q[n].ca, exp_word(a), LAT, {8'h03, a});
    end
    exp_last1 = exp_word(a);
  endtask

  task automatic test_drop_midtx();
    bit ok;
    int c = 0;
    int n = ev_q.size();
    logic [23:0] a;
    a = 24'($urandom);
    mem[a[11:0]] = 8'hAA; mem[12'(a[11:0] + 12'd1)] = 8'h55;
    mem[12'(a[11:0] + 12'd2)] = 8'hAA; mem[12'(a[11:0] + 12'd3)] = 8'h55;
    m0_addr = a; m0_req = 1'b1;
    while ((flash_csn || nbits < 10) && c < TX_BUDGET) begin @(posedge clk); c++; end
    #1;
    m0_req = 1'b0; m0_addr = 24'($urandom);
    wait_evs(n + 1, ok);
    repeat (300) @(posedge clk); #1;
    checks++;
    if (ev_q.size() !== n + 1) begin
      errors++; $display("FAIL drop_ack_count got %0d exp %0d", ev_q.size(), n + 1); return;
    end
    checks++;
    if (ev_q[n].port !== 0 || ev_q[n].data !== 32'h55AA55AA || ev_q[n].ca !== {8'h03, a} ||
        ev_q[n].enerr !== 0) begin
      errors++;
      $display("FAIL drop_tx got port %0d data %h ca %h enerr %0d exp port 0 data 55aa55aa ca %h enerr 0",
               ev_q[n].port, ev_q[n].data, ev_q[n].ca, ev_q[n].enerr, {8'h03, a});
    end
    exp_last0 = 32'h55AA55AA;
  endtask

  task automatic test_random();
    logic [23:0] aq0[$], aq1[$], a;
    int n0 = ev_q.size();
    int b0 = ack_cnt0, b1 = ack_cnt1, d0 = dbl_ack;
    fork
      begin
        bit ok = 1'b1;
        for (int k = 0; k < 8 && ok; k++) begin
          repeat ($urandom_range(0, 30)) @(posedge clk);
          #1 m0_addr = 24'($urandom); aq0.push_back(m0_addr); m0_req = 1'b1;
          wait_port(0, b0 + k + 1, ok);
          m0_req = 1'b0;
        end
      end
      begin
        bit ok = 1'b1;
        for (int k = 0; k < 8 && ok; k++) begin
          repeat ($urandom_range(0, 30)) @(posedge clk);
          #1 m1_addr = 24'($urandom); aq1.push_back(m1_addr); m1_req = 1'b1;
          wait_port(1, b1 + k + 1, ok);
          m1_req = 1'b0;
        end
      end
    join
    repeat (50) @(posedge clk); #1;
    for (int i = n0; i < ev_q.size(); i++) begin
      checks++;
      if ((ev_q[i].port == 0 && aq0.size() == 0) || (ev_q[i].port == 1 && aq1.size() == 0)) begin
        errors++; $display("FAIL rand_extra_ack got port %0d exp none", ev_q[i].port);
      end else begin
        a = (ev_q[i].port == 0) ? aq0.pop_front() : aq1.pop_front();
        if (ev_q[i].data !== exp_word(a) || ev_q[i].ca !== {8'h03, a} || ev_q[i].lat !== LAT ||
            ev_q[i].csn !== 1'b1 || ev_q[i].enerr !== 0) begin
          errors++;
          $display("FAIL rand_tx%0d got port %0d data %h ca %h lat %0d exp data %h ca %h lat %0d",
                   i, ev_q[i].port, ev_q[i].data, ev_q[i].ca, ev_q[i].lat, exp_word(a), {8'h03, a}, LAT);
        end
      end
    end
    checks++;
    if (aq0.size() != 0 || aq1.size() != 0 || dbl_ack !== d0) begin
      errors++; $display("FAIL rand_outstanding got %0d/%0d dbl %0d exp 0/0 dbl %0d",
                         aq0.size(), aq1.size(), dbl_ack, d0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_back_to_back();
    test_reset_midtx();
    test_drop_midtx();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- SPI flash read controller (mode 0, single-bit, command 0x03) that shares the external serial flash between two requesters, e.g. instruction fetch and data/bootloader port.
- Sits between the SoC bus bridges and the flash pin-level I/O buffers.
- Arbitrates round-robin, sequences CS/SCK/MOSI, shifts in one 32-bit little-endian word per transaction.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period (>=1).
- GAP_CYCLES, 4, minimum clk cycles flash_csn stays high between transactions (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- m0_req  in  1  requester 0 read request, held until m0_ack
- m0_addr  in  24  requester 0 byte address
- m0_ack  out  1  one-cycle pulse, m0_rdata valid this cycle
- m0_rdata  out  32  read data for requester 0
- m1_req  in  1  requester 1 read request
- m1_addr  in  24  requester 1 byte address
- m1_ack  out  1  one-cycle pulse for requester 1
- m1_rdata  out  32  read data for requester 1
- flash_clk  out  1  SPI SCK
- flash_csn  out  1  SPI chip select, active low
- flash_io0_en  out  1  MOSI output enable
- flash_io0_out  out  1  MOSI data
- flash_io0_in  in  1  unused, ignored
- flash_io1_en  out  1  constant 0
- flash_io1_out  out  1  constant 0
- flash_io1_in  in  1  MISO

Behaviour:
- Reset: flash_csn=1, flash_clk=0, io0_en=0, io0_out=0, m*_ack=0, m*_rdata=0, state=IDLE, last_grant=1 so m0 wins the first tie.
- Reset assertion is asynchronous and takes effect mid-transaction: CS deasserts immediately, no ack issued, the partial word is discarded.
- States:
  - IDLE: on a clk edge with any req, grant the requester and latch its address; csn<=0, io0_en<=1, io0_out<=cmd bit7; go to SHIFT.
  - SHIFT: transfers 64 bits (8 cmd 0x03, 24 addr MSB first, 32 data). Each bit is CLK_DIV cycles SCK low, then CLK_DIV cycles SCK high.
    - MOSI updates on SCK falling edge, i.e. the same clk edge flash_clk drops.
    - MISO is sampled on the clk edge where flash_clk rises.
    - io0_en drops to 0 at the falling edge that starts data bit 0.
  - Completion: after the 64th high phase, on the edge flash_clk returns to 0: csn<=1, io0_en<=0, pulse granted ack for one cycle, drive rdata; go to GAP.
  - GAP: count GAP_CYCLES with csn high, then IDLE. Requests are not granted in GAP.
- Data order:
  - Flash byte at addr goes to rdata[7:0], addr+1 to [15:8], addr+2 to [23:16], addr+3 to [31:24].
  - Bits within a byte arrive MSB first.
  - No alignment is enforced; any 24-bit address is legal and the flash wraps per its own rules.
- Latency: ack is asserted exactly 128*CLK_DIV+1 clk cycles after the edge csn fell (257 for CLK_DIV=2).
- Arbitration:
  - Round-robin on simultaneous req in IDLE: grant the requester not in last_grant, then update last_grant.
  - A lone requester is granted regardless of last_grant.
- Request rules:
  - req/addr are sampled only at grant.
  - Deasserting req mid-transaction does not abort it; ack still pulses once.
  - A requester still asserting req the cycle after ack is treated as a new request.
- rdata of the non-granted port holds its previous value; the ack of the non-granted port stays 0.
- Counters: bit counter 7 bits (0..64), divider counter sized for CLK_DIV-1, gap counter sized for GAP_CYCLES; no wrap beyond these bounds.

Test Plan:
- Single read, CLK_DIV=2: m0_req with addr 0x000100; flash model holds 0x11,0x22,0x33,0x44 → MOSI stream 0x03,0x00,0x01,0x00; m0_rdata=0x44332211; m0_ack 257 cycles after csn falls; csn high same cycle.
- Simultaneous m0_req/m1_req after reset → m0 served first, then csn high ≥4 cycles, then m1 served; each ack exactly once.
- Both requests held continuously for 6 transactions → grant order m0,m1,m0,m1,m0,m1.
- m1 only, two back-to-back requests (addr 0x000000, 0x000004) → both served by m1, rdata matches model, m0_ack never asserts.
- Async reset pulse during the data phase (bit 40) → csn=1 and flash_clk=0 the same cycle without waiting for a clk edge, no ack; next request completes normally.
- m0_req dropped at bit 10 → transaction completes, single m0_ack; MISO sampled only on rising SCK, verified via a model that toggles MISO on falling edges.
